// File: rtl/iterative_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative shift-add MUL and
// restoring DIV/MOD, fronted by a valid/ready handshake with busy and flag outputs.
module iterative_alu #(
  parameter int WORD_SIZE = 64,
  parameter int OP_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] A,
  input  logic [WORD_SIZE-1:0] B,
  input  logic [OP_WIDTH-1:0]  op,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out,
  output logic                 zero,
  output logic                 div0,
  output logic                 busy
);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SL  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_NOT = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_EQ  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_NEQ = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_LT  = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_LE  = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_GT  = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_GE  = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] OP_MOD = OP_WIDTH'(15);

  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam logic [WORD_SIZE-1:0] WIDTH_VAL = WORD_SIZE'(WORD_SIZE);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] a_reg, b_reg;
  logic [OP_WIDTH-1:0]  op_reg;
  logic [WORD_SIZE-1:0] acc, a_sh, b_sh;

  logic                 iter_in, div_zero_in, div_zero_reg;
  logic [WORD_SIZE:0]   rem_shift;
  logic [WORD_SIZE-1:0] rem_diff;
  logic                 rem_fits;
  logic [WORD_SIZE-1:0] single_result, final_result;

  assign iter_in      = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  assign div_zero_in  = ((op == OP_DIV) || (op == OP_MOD)) && (B == '0);
  assign div_zero_reg = ((op_reg == OP_DIV) || (op_reg == OP_MOD)) && (b_reg == '0);

  // The true difference is below the divisor, so W bits of the subtraction suffice.
  assign rem_shift = {acc, a_sh[WORD_SIZE-1]};
  assign rem_fits  = rem_shift >= {1'b0, b_sh};
  assign rem_diff  = rem_shift[WORD_SIZE-1:0] - b_sh;

  always_comb begin
    single_result = '0;
    case (op_reg)
      OP_ADD: single_result = a_reg + b_reg;
      OP_SUB: single_result = a_reg - b_reg;
      OP_SL:  single_result = (b_reg >= WIDTH_VAL) ? '0 : (a_reg << b_reg);
      OP_NOT: single_result = ~a_reg;
      OP_OR:  single_result = a_reg | b_reg;
      OP_AND: single_result = a_reg & b_reg;
      OP_XOR: single_result = a_reg ^ b_reg;
      OP_EQ:  single_result = WORD_SIZE'(a_reg == b_reg);
      OP_NEQ: single_result = WORD_SIZE'(a_reg != b_reg);
      OP_LT:  single_result = WORD_SIZE'(a_reg <  b_reg);
      OP_LE:  single_result = WORD_SIZE'(a_reg <= b_reg);
      OP_GT:  single_result = WORD_SIZE'(a_reg >  b_reg);
      OP_GE:  single_result = WORD_SIZE'(a_reg >= b_reg);
      default: single_result = '0;
    endcase
  end

  always_comb begin
    final_result = single_result;
    if (op_reg == OP_MUL)
      final_result = acc;
    else if (op_reg == OP_DIV)
      final_result = (b_reg == '0) ? '1 : a_sh;
    else if (op_reg == OP_MOD)
      final_result = (b_reg == '0) ? a_reg : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b1;
      div0      <= 1'b0;
      busy      <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            a_reg    <= A;
            b_reg    <= B;
            op_reg   <= op;
            acc      <= '0;
            a_sh     <= A;
            b_sh     <= B;
            if (iter_in && !div_zero_in) begin
              state <= ITER;
              busy  <= 1'b1;
              cnt   <= CNT_W'(WORD_SIZE - 1);
            end else begin
              state <= DONE;
            end
          end
        end
        // MUL shifts the multiplier out LSB first; DIV/MOD shift the dividend out
        // MSB first while quotient bits shift into the vacated low end of a_sh.
        ITER: begin
          if (op_reg == OP_MUL) begin
            if (b_sh[0])
              acc <= acc + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
          end else begin
            acc  <= rem_fits ? rem_diff : rem_shift[WORD_SIZE-1:0];
            a_sh <= {a_sh[WORD_SIZE-2:0], rem_fits};
          end
          if (cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          out       <= final_result;
          zero      <= (final_result == '0);
          div0      <= div_zero_reg;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
